alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's 2-bit-opcode combinational ALU. It accepts one operation per cycle over a valid/ready input port and computes the result and status flags in a combinational core. Each result is buffered in a 2-entry output queue drained over a valid/ready output port. An internal accumulator can replace operand A, so chained arithmetic runs without round-tripping results.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu_pipe.sv | 93 +++++++++
 tb/tb_alu_pipe.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU pipeline:
// op encodings, flag bundle and queue depth.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_PASS = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic carry;
      logic ovf;
      logic zero;
   } alu_flags_t;

   localparam int QUEUE_DEPTH = 2;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation and result handshake bundle for alu_pipe.
// master drives operations; slave is the ALU.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   alu_op_e          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             acc_sel;
   logic             acc_wr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   alu_flags_t       flags;
   logic [WIDTH-1:0] acc;

   modport master (
      output in_valid, op, a, b, acc_sel, acc_wr, out_ready,
      input  in_ready, out_valid, out, flags, acc
   );

   modport slave (
      input  in_valid, op, a, b, acc_sel, acc_wr, out_ready,
      output in_ready, out_valid, out, flags, acc
   );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: result plus carry/overflow/zero.
// Shifts use the low clog2(WIDTH) bits of B as amount.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output alu_flags_t       flags
);

   localparam int S   = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   logic [S-1:0] sh;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;
   logic [WIDTH:0] shl_w;
   logic [WIDTH:0] shr_w;

   assign sh = b[S-1:0];

   // Extra bit on each side captures the last bit shifted out
   assign sum   = {1'b0, a} + {1'b0, b};
   assign dif   = {1'b0, a} - {1'b0, b};
   assign shl_w = {1'b0, a} << sh;
   assign shr_w = {a, 1'b0} >> sh;

   always_comb begin
      result = '0;
      flags  = '0;
      unique case (op)
         OP_ADD: begin
            result      = sum[WIDTH-1:0];
            flags.carry = sum[WIDTH];
            flags.ovf   = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
         end
         OP_SUB: begin
            result      = dif[WIDTH-1:0];
            flags.carry = dif[WIDTH];
            flags.ovf   = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL: begin
            result      = shl_w[WIDTH-1:0];
            flags.carry = shl_w[WIDTH];
         end
         OP_SHR: begin
            result      = shr_w[WIDTH:1];
            flags.carry = shr_w[0];
         end
         OP_PASS: result = b;
      endcase
      flags.zero = (result == '0);
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with accumulator and a 2-entry result queue.
// Queue is head/tail registers so out/flags come straight from flops.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic       clk,
   input logic       reset,
   alu_pipe_if.slave io
);

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] res;
   alu_flags_t       res_flags;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] head_res_q, head_res_d;
   alu_flags_t       head_flg_q, head_flg_d;
   logic [WIDTH-1:0] tail_res_q, tail_res_d;
   alu_flags_t       tail_flg_q, tail_flg_d;
   logic [1:0]       cnt_q, cnt_d;

   logic in_ready;
   logic push;
   logic pop;

   assign opa = io.acc_sel ? acc_q : io.a;

   alu_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .op    (io.op),
      .a     (opa),
      .b     (io.b),
      .result(res),
      .flags (res_flags)
   );

   assign in_ready = !reset && (cnt_q < 2'(QUEUE_DEPTH));
   assign push     = io.in_valid && in_ready;
   assign pop      = (cnt_q != 2'd0) && io.out_ready;

   always_comb begin
      acc_d      = acc_q;
      head_res_d = head_res_q;
      head_flg_d = head_flg_q;
      tail_res_d = tail_res_q;
      tail_flg_d = tail_flg_q;
      cnt_d      = cnt_q + 2'(push) - 2'(pop);
      if (push && io.acc_wr)
         acc_d = res;
      if (pop && cnt_q == 2'd2) begin
         head_res_d = tail_res_q;
         head_flg_d = tail_flg_q;
      end
      // New entry lands at head when head is empty or leaving now
      if (push) begin
         if (cnt_q == 2'd0 || pop) begin
            head_res_d = res;
            head_flg_d = res_flags;
         end else begin
            tail_res_d = res;
            tail_flg_d = res_flags;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         head_res_q <= '0;
         head_flg_q <= '0;
         tail_res_q <= '0;
         tail_flg_q <= '0;
         cnt_q      <= '0;
      end else begin
         acc_q      <= acc_d;
         head_res_q <= head_res_d;
         head_flg_q <= head_flg_d;
         tail_res_q <= tail_res_d;
         tail_flg_q <= tail_flg_d;
         cnt_q      <= cnt_d;
      end
   end

   assign io.in_ready  = in_ready;
   assign io.out_valid = (cnt_q != 2'd0);
   assign io.out       = head_res_q;
   assign io.flags     = head_flg_q;
   assign io.acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table plus
// backpressure, drain and mid-operation reset sequences.
module tb_alu_pipe;
   import alu_pkg::*;

   typedef struct {
      alu_op_e    op;
      logic [7:0] a;
      logic [7:0] b;
      logic       sel;
      logic       wr;
      logic [7:0] eo;
      logic [2:0] ef;
   } vec_t;

   localparam int NV = 18;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   accepted;
   vec_t vecs [NV];

   alu_pipe_if #(.WIDTH(8)) bus ();

   alu_pipe #(
      .WIDTH(8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .io   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input alu_op_e op, input logic [7:0] a,
                        input logic [7:0] b, input logic sel,
                        input logic wr);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.acc_sel  = sel;
      bus.acc_wr   = wr;
   endtask

   initial begin
      // carry,ovf,zero
      vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 0, 0, 8'h80, 3'b010};
      vecs[1]  = '{OP_SUB,  8'h00, 8'h01, 0, 0, 8'hFF, 3'b100};
      vecs[2]  = '{OP_ADD,  8'hFF, 8'h01, 0, 0, 8'h00, 3'b101};
      vecs[3]  = '{OP_SHL,  8'h81, 8'h01, 0, 0, 8'h02, 3'b100};
      vecs[4]  = '{OP_SHR,  8'h81, 8'h09, 0, 0, 8'h40, 3'b100};
      vecs[5]  = '{OP_SHL,  8'h5A, 8'h00, 0, 0, 8'h5A, 3'b000};
      vecs[6]  = '{OP_SUB,  8'h80, 8'h01, 0, 0, 8'h7F, 3'b010};
      vecs[7]  = '{OP_AND,  8'hF0, 8'h3C, 0, 0, 8'h30, 3'b000};
      vecs[8]  = '{OP_OR,   8'h00, 8'h00, 0, 0, 8'h00, 3'b001};
      vecs[9]  = '{OP_XOR,  8'hAA, 8'hAA, 0, 0, 8'h00, 3'b001};
      vecs[10] = '{OP_PASS, 8'h12, 8'h34, 0, 0, 8'h34, 3'b000};
      vecs[11] = '{OP_SHR,  8'h80, 8'h07, 0, 0, 8'h01, 3'b000};
      vecs[12] = '{OP_SHL,  8'h03, 8'h07, 0, 0, 8'h80, 3'b100};
      vecs[13] = '{OP_OR,   8'h81, 8'h06, 0, 0, 8'h87, 3'b000};
      vecs[14] = '{OP_PASS, 8'hFF, 8'h05, 0, 1, 8'h05, 3'b000};
      vecs[15] = '{OP_ADD,  8'hFF, 8'h03, 1, 1, 8'h08, 3'b000};
      vecs[16] = '{OP_ADD,  8'hFF, 8'h03, 1, 1, 8'h0B, 3'b000};
      vecs[17] = '{OP_ADD,  8'hFF, 8'h03, 1, 1, 8'h0E, 3'b000};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = OP_ADD;
      bus.a         = '0;
      bus.b         = '0;
      bus.acc_sel   = 1'b0;
      bus.acc_wr    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out", bus.out, 0);
      check("rst_flags", bus.flags, 0);
      check("rst_acc", bus.acc, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rel_in_ready", bus.in_ready, 1);
      check("rel_out_valid", bus.out_valid, 0);

      // Back-to-back ops; each result is head one cycle later
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].wr);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_valid", i), bus.out_valid, 1);
         check($sformatf("v%0d_out", i), bus.out, vecs[i].eo);
         check($sformatf("v%0d_flags", i), bus.flags, vecs[i].ef);
      end
      bus.in_valid = 1'b0;
      check("chain_acc", bus.acc, 8'h0E);
      @(posedge clk);
      #1;
      check("drain_empty", bus.out_valid, 0);

      // Backpressure: offer 4, expect 2 accepted
      bus.out_ready = 1'b0;
      accepted = 0;
      for (int k = 0; k < 4; k++) begin
         drive(OP_PASS, 8'h00, 8'(8'h11 * (k + 1)), 0, 0);
         if (bus.in_ready) accepted++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("bp_accepted", accepted, 2);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_out", bus.out, 8'h11);
      check("bp_hold_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("pop1_out", bus.out, 8'h22);
      check("pop1_in_ready", bus.in_ready, 1);
      check("pop1_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      check("pop2_empty", bus.out_valid, 0);

      // Refill two entries, then reset mid-operation
      bus.out_ready = 1'b0;
      drive(OP_PASS, 8'h00, 8'h55, 0, 0);
      @(posedge clk);
      #1;
      drive(OP_PASS, 8'h00, 8'h66, 0, 0);
      @(posedge clk);
      #1;
      check("full_in_ready", bus.in_ready, 0);
      check("full_acc", bus.acc, 8'h0E);
      bus.out_ready = 1'b1;
      drive(OP_ADD, 8'h00, 8'h77, 0, 1);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_acc", bus.acc, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      check("mid_rst_out", bus.out, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("post_in_ready", bus.in_ready, 1);
      check("post_valid", bus.out_valid, 0);
      check("post_acc", bus.acc, 0);
      drive(OP_ADD, 8'hFF, 8'h02, 1, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("post_op_valid", bus.out_valid, 1);
      check("post_op_out", bus.out, 8'h02);
      check("post_op_flags", bus.flags, 3'b000);
      @(posedge clk);
      #1;
      check("post_op_drain", bus.out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
